// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder
//
// Instruction-fetch memory model that answers an Ibex-style req/gnt/rvalid
// fetch port from a 32-bit backing store. An accepted request samples the
// store immediately, and the word travels down a fixed-depth pipeline. The
// response pops out exactly Latency cycles later, strictly in acceptance order.
//
// Handshake: a request is accepted in a cycle where instr_req_i and
// instr_gnt_o are both high. instr_gnt_o is combinational. Responses are
// single-cycle instr_rvalid_o strobes. They cannot be refused, so the initiator
// must take (or drop) the data in that cycle.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   instr_req_i       fetch request
//   instr_addr_i      byte address (bits [1:0] ignored)
//   instr_gnt_o       request accepted this cycle
//   instr_rvalid_o    response strobe
//   instr_rdata_o     response word (0 when no response)
//   instr_err_o       response address was outside the store
//   stall_i           withholds grants while high
//   mem_we_i          backing-store write enable (loader port)
//   mem_waddr_i       word index to write
//   mem_wdata_i       data to write
module ibex_instr_mem_responder #(
    parameter int AddrWidth      = 94,
    parameter int MemWords       = 1024,
    parameter int Latency        = 1,
    parameter int MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_req_i,
    input  logic [AddrWidth-1:0]        instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        stall_i,
    input  logic                        mem_we_i,
    input  logic [$clog2(MemWords)-1:0] mem_waddr_i,
    input  logic [31:0]                 mem_wdata_i
);

    localparam int IdxW = $clog2(MemWords);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [31:0]         mem_q [MemWords];

    logic [Latency-1:0]  valid_q, valid_d;
    logic [Latency-1:0]  err_q, err_d;
    logic [31:0]         data_q [Latency];
    logic [31:0]         data_d [Latency];
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [IdxW-1:0]     rd_idx;
    logic                addr_oor;
    logic                accept;
    logic                rsp_valid;
    logic [CntW-1:0]     cnt_after_rsp;
    logic                unused_addr_lsbs;

    assign rd_idx           = instr_addr_i[IdxW+1:2];
    assign addr_oor         = |instr_addr_i[AddrWidth-1:IdxW+2];
    assign unused_addr_lsbs = ^instr_addr_i[1:0];

    // Reset masks the response outputs combinationally so nothing leaks out
    // in the cycle where reset is first raised.
    assign rsp_valid      = valid_q[Latency-1];
    assign instr_rvalid_o = rsp_valid & ~rst_i;
    assign instr_rdata_o  = instr_rvalid_o ? data_q[Latency-1] : 32'h0;
    assign instr_err_o    = instr_rvalid_o & err_q[Latency-1];

    // A slot released by this cycle's response is already available for a
    // new grant in the same cycle.
    assign cnt_after_rsp = cnt_q - CntW'(instr_rvalid_o);
    assign instr_gnt_o   = instr_req_i & ~stall_i & ~rst_i &
                           (cnt_after_rsp < CntW'(MaxOutstanding));
    assign accept        = instr_req_i & instr_gnt_o;

    always_comb begin
        valid_d    = '0;
        err_d      = '0;
        data_d     = data_q;
        cnt_d      = cnt_q;

        // Stage 0 captures the store in the acceptance cycle; a write in that
        // same cycle lands at the edge, so the read sees the old word.
        valid_d[0] = accept;
        err_d[0]   = accept & addr_oor;
        data_d[0]  = (accept && !addr_oor) ? mem_q[rd_idx] : 32'h0;
        for (int i = 1; i < Latency; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = data_q[i-1];
        end

        case ({accept, rsp_valid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (rst_i) begin
            valid_d = '0;
            err_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        valid_q <= valid_d;
        err_q   <= err_d;
        data_q  <= data_d;
        cnt_q   <= cnt_d;
    end

    // Backing store is never reset; the loader port keeps working in reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem_q[mem_waddr_i] <= mem_wdata_i;
        end
    end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
module tb_ibex_instr_mem_responder;

    localparam int AW   = 94;
    localparam int MW   = 1024;
    localparam int IW   = 10;
    localparam int LAT  = 2;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req, stall, we;
    logic [AW-1:0] addr;
    logic [IW-1:0] waddr;
    logic [31:0]   wdata;
    logic          gnt, rvalid, err;
    logic [31:0]   rdata;

    logic          rst3, req3;
    logic          gnt3, rvalid3, err3;
    logic [31:0]   rdata3;

    int checks = 0;
    int errors = 0;

    ibex_instr_mem_responder #(
        .AddrWidth(AW), .MemWords(MW), .Latency(LAT), .MaxOutstanding(MAXO)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
        .instr_err_o(err), .stall_i(stall), .mem_we_i(we),
        .mem_waddr_i(waddr), .mem_wdata_i(wdata)
    );

    ibex_instr_mem_responder #(
        .AddrWidth(AW), .MemWords(MW), .Latency(3), .MaxOutstanding(1)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .instr_req_i(req3), .instr_addr_i('0),
        .instr_gnt_o(gnt3), .instr_rvalid_o(rvalid3), .instr_rdata_o(rdata3),
        .instr_err_o(err3), .stall_i(1'b0), .mem_we_i(1'b0),
        .mem_waddr_i('0), .mem_wdata_i('0)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // ---------------- reference model ----------------
    // Outstanding requests are a queue of pending responses, each tagged with
    // the cycle it is due in. Checked every cycle on the falling edge.
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        mq[$];
    logic [31:0] mem_model [MW];
    int          ncyc = 0;
    logic        m_rv, m_gnt, m_oor;
    rsp_t        m_new;

    always @(negedge clk) begin
        m_rv  = !rst && mq.size() > 0 && mq[0].due == ncyc;
        m_gnt = req && !stall && !rst && (int'(mq.size()) - int'(m_rv) < MAXO);
        chk("m_gnt", 32'(gnt), 32'(m_gnt));
        chk("m_rvalid", 32'(rvalid), 32'(m_rv));
        if (m_rv) begin
            chk("m_rdata", rdata, mq[0].data);
            chk("m_err", 32'(err), 32'(mq[0].err));
            void'(mq.pop_front());
        end else begin
            chk("m_rdata_idle", rdata, 32'h0);
            chk("m_err_idle", 32'(err), 32'h0);
        end
        if (rst) begin
            mq.delete();
        end else if (m_gnt) begin
            m_oor      = (addr >> (IW + 2)) != 0;
            m_new.due  = ncyc + LAT;
            m_new.err  = m_oor;
            m_new.data = m_oor ? 32'h0 : mem_model[IW'(addr >> 2)];
            mq.push_back(m_new);
        end
        if (we) mem_model[waddr] = wdata;
        ncyc++;
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          req, stall, we;
        logic [AW-1:0] addr;
        logic [IW-1:0] waddr;
        logic [31:0]   wdata;
        logic          e_gnt, e_rv;
        logic [31:0]   e_data;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rq, logic st, logic w, logic [AW-1:0] a,
                                logic [IW-1:0] wa, logic [31:0] wd,
                                logic eg, logic erv, logic [31:0] ed, logic ee);
        vec_t v;
        v.req = rq; v.stall = st; v.we = w; v.addr = a; v.waddr = wa; v.wdata = wd;
        v.e_gnt = eg; v.e_rv = erv; v.e_data = ed; v.e_err = ee;
        tbl.push_back(v);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(string nm, logic eg, logic erv, logic [31:0] ed, logic ee);
        @(negedge clk);
        chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
        chk({nm, "_rvalid"}, 32'(rvalid), 32'(erv));
        chk({nm, "_rdata"}, rdata, ed);
        chk({nm, "_err"}, 32'(err), 32'(ee));
        next_cycle();
    endtask

    task automatic idle_inputs();
        req = 1'b0; stall = 1'b0; we = 1'b0; addr = '0; waddr = '0; wdata = '0;
    endtask

    logic [AW-1:0] hi_addr;
    int            w;

    initial begin
        rst = 1'b1; rst3 = 1'b1; req3 = 1'b0;
        idle_inputs();
        req = 1'b1;                   // request during reset must not be granted
        next_cycle();
        next_cycle();
        expect_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);

        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < MW; i++) begin
            we = 1'b1; waddr = IW'(i); wdata = pat(i);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        hi_addr = '0;
        hi_addr[AW-1] = 1'b1;
        //   req st we addr         wa  wdata           gnt rv data           err
        add(1, 0, 0, 94'h0,         0,  0,             1, 0, 32'h0,          0);
        add(1, 0, 0, 94'h4,         0,  0,             1, 0, 32'h0,          0);
        add(1, 0, 0, 94'h8,         0,  0,             1, 1, pat(0),         0);
        add(1, 0, 0, 94'hC,         0,  0,             1, 1, pat(1),         0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, pat(2),         0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, pat(3),         0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(1, 0, 0, 94'h10,        0,  0,             1, 0, 32'h0,          0);
        add(1, 1, 0, 94'h14,        0,  0,             0, 0, 32'h0,          0);
        add(1, 1, 0, 94'h14,        0,  0,             0, 1, pat(4),         0);
        add(1, 1, 0, 94'h14,        0,  0,             0, 0, 32'h0,          0);
        add(1, 0, 0, 94'h14,        0,  0,             1, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, pat(5),         0);
        add(1, 0, 0, 94'h1000,      0,  0,             1, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, 32'h0,          1);
        add(1, 0, 1, 94'h0,         0,  32'h1,         1, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, pat(0),         0);
        add(1, 0, 0, 94'h0,         0,  0,             1, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, 32'h1,          0);
        add(0, 0, 1, 94'h0,         5,  32'hDEADBEEF,  0, 0, 32'h0,          0);
        add(1, 0, 0, 94'h14,        0,  0,             1, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, 32'hDEADBEEF,   0);
        add(1, 0, 0, hi_addr | 94'h8, 0, 0,            1, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, 32'h0,          1);
        add(1, 0, 0, 94'h1B,        0,  0,             1, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 0, 32'h0,          0);
        add(0, 0, 0, 94'h0,         0,  0,             0, 1, pat(6),         0);

        foreach (tbl[i]) begin
            req = tbl[i].req; stall = tbl[i].stall; we = tbl[i].we;
            addr = tbl[i].addr; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            expect_out($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_rv,
                       tbl[i].e_data, tbl[i].e_err);
        end
        idle_inputs();

        // Reset one cycle after acceptance: the response must never appear,
        // and the store must survive the reset.
        req = 1'b1; addr = 94'h8;
        expect_out("rst_acc", 1'b1, 1'b0, 32'h0, 1'b0);
        rst = 1'b1; req = 1'b1;
        expect_out("rst_in", 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0; req = 1'b0;
        expect_out("rst_drop0", 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("rst_drop1", 1'b0, 1'b0, 32'h0, 1'b0);
        req = 1'b1; addr = 94'h8;
        expect_out("rst_reacc", 1'b1, 1'b0, 32'h0, 1'b0);
        req = 1'b0;
        expect_out("rst_wait", 1'b0, 1'b0, 32'h0, 1'b0);
        expect_out("rst_keep", 1'b0, 1'b1, pat(2), 1'b0);

        // Latency 3, one outstanding: continuous request is granted every
        // third cycle, each grant coinciding with the previous response.
        rst3 = 1'b0; req3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("l3_gnt%0d", k), 32'(gnt3), 32'(k % 3 == 0));
            chk($sformatf("l3_rv%0d", k), 32'(rvalid3), 32'(k > 0 && k % 3 == 0));
            next_cycle();
        end
        req3 = 1'b0;

        // Randomized traffic checked by the reference model.
        for (int n = 0; n < 500; n++) begin
            rst   = ($urandom_range(0, 60) == 0);
            req   = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 5) == 0);
            we    = ($urandom_range(0, 3) == 0);
            waddr = IW'($urandom_range(0, MW - 1));
            wdata = $urandom;
            w     = $urandom_range(0, MW - 1);
            addr  = (AW'(w) << 2) | AW'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = addr | (AW'(1) << $urandom_range(IW + 2, AW - 1));
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        for (int n = 0; n < 6; n++) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
